// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe.
// The master drives operands and out_ready; the slave is the adder.
interface cla_adder_pipe_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_sat;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_cout,
    input  out_ovf,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_cout,
    output out_ovf,
    output out_sat
  );

endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead add/sub with saturation and flags.
// Each stage resolves one SEG-bit slice; the beat carries its state.
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_adder_pipe_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = (SEG + GROUP - 1) / GROUP;

  localparam logic [WIDTH-1:0] SAT_MAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic             vld;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cy;
    logic             ovf;
    logic             sat;
  } beat_t;

  beat_t st_q [STAGES];
  beat_t st_d [STAGES];

  beat_t          in_st;
  beat_t          src;
  beat_t          nxt;
  logic [SEG-1:0] ga;
  logic [SEG-1:0] gb;
  logic [SEG:0]   cc;
  logic           advance;
  logic           unused_last;

  // Two-level lookahead: group G/P, then every carry
  // expands from its group carry-in, never bit-to-bit.
  function automatic logic [SEG:0] seg_carry(
    input logic [SEG-1:0] g,
    input logic [SEG-1:0] p,
    input logic           cin
  );
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [NG:0]   cg;
    logic [SEG:0]  c;
    logic          tg;
    logic          tp;
    int            base;
    gg = '0;
    pg = '1;
    cg = '0;
    c  = '0;
    for (int m = 0; m < NG; m++) begin
      for (int i = 0; i < GROUP; i++) begin
        if (m * GROUP + i < SEG) begin
          gg[m] = g[m*GROUP+i]
                | (p[m*GROUP+i] & gg[m]);
          pg[m] = pg[m] & p[m*GROUP+i];
        end
      end
    end
    cg[0] = cin;
    for (int m = 1; m <= NG; m++) begin
      tg = 1'b0;
      tp = 1'b1;
      for (int n = 0; n < NG; n++) begin
        if (n < m) begin
          tg = gg[n] | (pg[n] & tg);
          tp = tp & pg[n];
        end
      end
      cg[m] = tg | (tp & cin);
    end
    for (int j = 0; j < SEG; j++) begin
      tg   = 1'b0;
      tp   = 1'b1;
      base = (j / GROUP) * GROUP;
      for (int i = 0; i < GROUP; i++) begin
        if (base + i < j) begin
          tg = g[base+i] | (p[base+i] & tg);
          tp = tp & p[base+i];
        end
      end
      c[j] = tg | (tp & cg[j/GROUP]);
    end
    c[SEG] = cg[NG];
    return c;
  endfunction

  assign advance = !st_q[STAGES-1].vld
                 | bus.out_ready;

  always_comb begin
    in_st     = '0;
    in_st.vld = bus.in_valid;
    in_st.op  = bus.in_op;
    in_st.a   = bus.in_a;
    in_st.b   = bus.in_op[0] ? ~bus.in_b
                             : bus.in_b;
    in_st.cy  = bus.in_op[0];
  end

  always_comb begin
    src = '0;
    nxt = '0;
    ga  = '0;
    gb  = '0;
    cc  = '0;
    for (int k = 0; k < STAGES; k++) begin
      src = (k == 0) ? in_st
                     : st_q[(k == 0) ? 0 : k-1];
      ga  = src.a[k*SEG +: SEG];
      gb  = src.b[k*SEG +: SEG];
      cc  = seg_carry(ga & gb, ga ^ gb, src.cy);
      nxt = src;
      nxt.sum[k*SEG +: SEG] = (ga ^ gb)
                            ^ cc[SEG-1:0];
      nxt.cy  = cc[SEG];
      nxt.ovf = cc[SEG] ^ cc[SEG-1];
      nxt.sat = src.op[1] & nxt.ovf;
      // Clamp only once the top slice is resolved.
      if (k == STAGES-1 && nxt.sat) begin
        nxt.sum = src.a[WIDTH-1] ? SAT_MIN
                                 : SAT_MAX;
      end
      st_d[k] = advance ? nxt : st_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = st_q[STAGES-1].vld;
  assign bus.out_sum   = st_q[STAGES-1].sum;
  assign bus.out_cout  = st_q[STAGES-1].cy;
  assign bus.out_ovf   = st_q[STAGES-1].ovf;
  assign bus.out_sat   = st_q[STAGES-1].sat;

  assign unused_last = ^st_q[STAGES-1];

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed and scoreboarded checks for cla_adder_pipe
// at WIDTH=8, GROUP=3, STAGES=2.
module tb_cla_adder_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic clk;
  logic rst_n;

  cla_adder_pipe_if #(.WIDTH(W)) bus ();

  cla_adder_pipe #(
    .WIDTH (W),
    .GROUP (3),
    .STAGES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc;
  int n_out;
  int first_cyc;
  int last_cyc;
  logic stall_prev;
  logic [10:0] held;
  logic [10:0] expq [$];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] op
  );
    logic [7:0] bb;
    logic [8:0] f;
    logic       ov;
    logic       sat;
    logic [7:0] s;
    bb  = op[0] ? ~b : b;
    f   = {1'b0, a} + {1'b0, bb}
        + {8'd0, op[0]};
    ov  = (a[7] == bb[7]) && (f[7] != a[7]);
    sat = op[1] & ov;
    s   = sat ? (a[7] ? 8'h80 : 8'h7F)
              : f[7:0];
    return {sat, ov, f[8], s};
  endfunction

  function automatic logic [10:0] outv();
    return {bus.out_sat, bus.out_ovf,
            bus.out_cout, bus.out_sum};
  endfunction

  task automatic dir(
    input string      tag,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] op,
    input logic [7:0] es,
    input logic       ec,
    input logic       eo,
    input logic       esat
  );
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_early"},
          32'(bus.out_valid), 0);
    repeat (S - 1) @(negedge clk);
    check({tag, "_vld"}, 32'(bus.out_valid), 1);
    check({tag, "_sum"}, 32'(bus.out_sum),
          32'(es));
    check({tag, "_cout"}, 32'(bus.out_cout),
          32'(ec));
    check({tag, "_ovf"}, 32'(bus.out_ovf),
          32'(eo));
    check({tag, "_sat"}, 32'(bus.out_sat),
          32'(esat));
  endtask

  task automatic step(
    input logic       v,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] op,
    input logic       rdy
  );
    @(negedge clk);
    if (stall_prev) begin
      check("stall_vld", 32'(bus.out_valid), 1);
      check("stall_hold", 32'(outv()),
            32'(held));
    end
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.out_ready = rdy;
    #1;
    check("in_ready", 32'(bus.in_ready),
          32'(!bus.out_valid | bus.out_ready));
    if (bus.out_valid && bus.out_ready) begin
      check("q_nonempty",
            32'(expq.size() != 0), 1);
      if (expq.size() != 0)
        check("result", 32'(outv()),
              32'(expq.pop_front()));
      n_out++;
      if (n_out == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (bus.in_valid && bus.in_ready)
      expq.push_back(model(a, b, op));
    stall_prev = bus.out_valid && !bus.out_ready;
    held = outv();
    cyc++;
  endtask

  task automatic flush_out();
    for (int i = 0; i < S + 3; i++)
      step(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    check("drained", 32'(expq.size()), 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    n_out = 0;
    first_cyc = 0;
    last_cyc = 0;
    stall_prev = 1'b0;
    held = '0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_vld", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(bus.in_ready), 1);
    check("rst_out", 32'(outv()), 0);

    dir("add_7f_01", 8'h7F, 8'h01, 2'b00,
        8'h80, 1'b0, 1'b1, 1'b0);
    dir("add_ff_01", 8'hFF, 8'h01, 2'b00,
        8'h00, 1'b1, 1'b0, 1'b0);
    dir("add_55_2b", 8'h55, 8'h2B, 2'b00,
        8'h80, 1'b0, 1'b1, 1'b0);
    dir("sat_7f_01", 8'h7F, 8'h01, 2'b10,
        8'h7F, 1'b0, 1'b1, 1'b1);
    dir("sat_80_ff", 8'h80, 8'hFF, 2'b10,
        8'h80, 1'b1, 1'b1, 1'b1);
    dir("sat_10_20", 8'h10, 8'h20, 2'b10,
        8'h30, 1'b0, 1'b0, 1'b0);
    dir("sub_00_01", 8'h00, 8'h01, 2'b01,
        8'hFF, 1'b0, 1'b0, 1'b0);
    dir("ssat_80_01", 8'h80, 8'h01, 2'b11,
        8'h80, 1'b1, 1'b1, 1'b1);
    dir("ssat_05_03", 8'h05, 8'h03, 2'b11,
        8'h02, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    n_out = 0;
    cyc = 0;
    for (int i = 0; i < 100; i++)
      step(1'b1, 8'($urandom), 8'($urandom),
           2'($urandom), 1'b1);
    flush_out();
    check("burst_cnt", 32'(n_out), 100);
    check("burst_span",
          32'(last_cyc - first_cyc), 99);
    check("burst_fill", 32'(first_cyc), S);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom),
           2'($urandom),
           1'($urandom_range(0, 2) != 0));
    flush_out();

    step(1'b1, 8'h12, 8'h34, 2'b00, 1'b0);
    step(1'b1, 8'h56, 8'h78, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(bus.out_valid), 0);
    check("mid_rst_out", 32'(outv()), 0);
    check("mid_rst_rdy", 32'(bus.in_ready), 1);
    expq.delete();
    stall_prev = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < S + 1; i++) begin
      @(negedge clk);
      check("post_rst_idle",
            32'(bus.out_valid), 0);
    end
    dir("post_rst", 8'h21, 8'h11, 2'b01,
        8'h10, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
